spec_peak_detect: RTL and testbench

Downstream stage of the pulse-accumulation buffer in the lidar signal chain. It consumes the accumulated power-spectrum stream: 64-bit words, one word per spectral point, FFT_POINTS points per range bin. For each range bin it reports the index and value of the spectral maximum inside the programmed band [low_lim, high_lim]. It is driven by the accumulation buffer's data/valid outputs and by the SPI command registers (UR_LowLim_Spec, UR_HighLim_Spec, UR_nRangeBins, Capture_En).

---
 rtl/spec_peak_detect.sv | 123 ++++++++++++
 tb/tb_spec_peak_detect.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spec_peak_detect.sv
// spec_peak_detect: per-range-bin spectral peak search inside a latched band; SPEC_BAND_SUM_EN adds the in-band power sum
module spec_peak_detect #(
  parameter int DATA_WIDTH = 64,
  parameter int FFT_POINTS = 512,
  parameter int IDX_WIDTH  = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          valid_in,
  input  logic                          capture_en,
  input  logic [15:0]                   low_lim,
  input  logic [15:0]                   high_lim,
  input  logic [15:0]                   n_range_bins,
  output logic [15:0]                   peak_idx_o,
  output logic [DATA_WIDTH-1:0]         peak_val_o,
  output logic [15:0]                   rb_idx_o,
  output logic                          peak_valid_o,
  output logic                          frame_done_o,
  output logic                          err_band_o,
  output logic [DATA_WIDTH+IDX_WIDTH-1:0] band_sum_o
);
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [15:0] LAST16 = 16'(FFT_POINTS - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_PT = IDX_WIDTH'(FFT_POINTS - 1);
  localparam logic [IDX_WIDTH-1:0] ONE_PT = 1;
  state_t state, state_nx;
  logic [IDX_WIDTH-1:0] pt_cnt, max_idx_q, idx_f;
  logic [15:0] rb_cnt, lo_q, hi_q, lo_e, hi_e, hi_c, pt16, rb_last;
  logic [DATA_WIDTH-1:0] max_q, max_f;
  logic ok_q, ok_e, have_q, have_f, take, start, abort, last, wrap, in_band, upd;
  // word qualification, band test against live limits on the frame's first word, running-max update, next state
  always_comb begin
    take     = capture_en && valid_in;
    start    = take && state == IDLE;
    abort    = !capture_en && state == SCAN;
    hi_c     = (high_lim > LAST16) ? LAST16 : high_lim;
    lo_e     = start ? low_lim : lo_q;
    hi_e     = start ? hi_c : hi_q;
    ok_e     = start ? (low_lim <= hi_c) : ok_q;
    pt16     = 16'(pt_cnt);
    in_band  = take && ok_e && pt16 >= lo_e && pt16 <= hi_e;
    upd      = in_band && (!have_q || data_in > max_q);
    max_f    = upd ? data_in : max_q;
    idx_f    = upd ? pt_cnt : max_idx_q;
    have_f   = have_q || in_band;
    last     = take && pt_cnt == LAST_PT;
    rb_last  = (n_range_bins == 16'd0) ? 16'd0 : n_range_bins - 16'd1;
    wrap     = rb_cnt >= rb_last;
    state_nx = abort ? IDLE : (last && wrap) ? IDLE : take ? SCAN : state;
  end
  // frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // counters, latched band, running max and registered per-bin result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_cnt       <= '0;
      rb_cnt       <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      ok_q         <= 1'b0;
      have_q       <= 1'b0;
      max_q        <= '0;
      max_idx_q    <= '0;
      peak_idx_o   <= 16'hFFFF;
      peak_val_o   <= '0;
      rb_idx_o     <= '0;
      peak_valid_o <= 1'b0;
      frame_done_o <= 1'b0;
      err_band_o   <= 1'b0;
    end else begin
      peak_valid_o <= last;
      frame_done_o <= last && wrap;
      if (abort) begin
        pt_cnt    <= '0;
        rb_cnt    <= '0;
        have_q    <= 1'b0;
        max_q     <= '0;
        max_idx_q <= '0;
      end else if (take) begin
        pt_cnt    <= last ? '0 : pt_cnt + ONE_PT;
        have_q    <= have_f && !last;
        max_q     <= last ? '0 : max_f;
        max_idx_q <= last ? '0 : idx_f;
        if (start) begin
          lo_q       <= lo_e;
          hi_q       <= hi_e;
          ok_q       <= ok_e;
          err_band_o <= !ok_e;
        end
        if (last) begin
          peak_idx_o <= have_f ? 16'(idx_f) : 16'hFFFF;
          peak_val_o <= have_f ? max_f : '0;
          rb_idx_o   <= rb_cnt;
          rb_cnt     <= wrap ? '0 : rb_cnt + 16'd1;
        end
      end
    end
  end
`ifdef SPEC_BAND_SUM_EN
  localparam int SW = DATA_WIDTH + IDX_WIDTH;
  logic [SW-1:0] sum_q, sum_f;
  // running in-band sum including the current word
  always_comb sum_f = sum_q + (in_band ? SW'(data_in) : '0);
  // sum accumulator, published with the peak result and restarted per bin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      band_sum_o <= '0;
    end else if (abort) begin
      sum_q <= '0;
    end else if (take) begin
      sum_q <= last ? '0 : sum_f;
      if (last) band_sum_o <= sum_f;
    end
  end
`else
  assign band_sum_o = '0;
`endif
endmodule

// File: tb/tb_spec_peak_detect.sv
// tb_spec_peak_detect: directed/randomized frames checked against a per-bin array reference model
module tb_spec_peak_detect;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [63:0] data_in = '0;
  logic valid_in = 1'b0, capture_en = 1'b0;
  logic [15:0] low_lim = '0, high_lim = '0, n_range_bins = 16'd1;
  logic [15:0] peak_idx_o, rb_idx_o;
  logic [63:0] peak_val_o;
  logic peak_valid_o, frame_done_o, err_band_o;
  logic [73:0] band_sum_o;
  int passed = 0, failed = 0, total = 0, cyc = 0, stray = 0;
  logic [63:0] mem [0:2047];
  logic [15:0] q_idx[$], q_rb[$];
  logic [63:0] q_val[$];
  logic [73:0] q_sum[$];
  logic q_done[$];
  int q_cyc[$], exp_cyc[$];

  spec_peak_detect dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in), .capture_en(capture_en),
    .low_lim(low_lim), .high_lim(high_lim), .n_range_bins(n_range_bins),
    .peak_idx_o(peak_idx_o), .peak_val_o(peak_val_o), .rb_idx_o(rb_idx_o),
    .peak_valid_o(peak_valid_o), .frame_done_o(frame_done_o), .err_band_o(err_band_o),
    .band_sum_o(band_sum_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (peak_valid_o) begin
      q_idx.push_back(peak_idx_o);
      q_val.push_back(peak_val_o);
      q_rb.push_back(rb_idx_o);
      q_done.push_back(frame_done_o);
      q_sum.push_back(band_sum_o);
      q_cyc.push_back(cyc);
    end
    if (frame_done_o && !peak_valid_o) stray <= stray + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_idx"}, peak_idx_o, 16'hFFFF);
    chk({tag, "_val"}, peak_val_o, 0);
    chk({tag, "_rb"}, rb_idx_o, 0);
    chk({tag, "_valid"}, peak_valid_o, 0);
    chk({tag, "_done"}, frame_done_o, 0);
    chk({tag, "_err"}, err_band_o, 0);
    chk({tag, "_sum"}, band_sum_o, 0);
  endtask

  // reference: first maximum over the clamped band of a bin, plus its sum
  task automatic model(input int b, input int lo, input int hi, output logic [15:0] idx,
                       output logic [63:0] val, output logic [73:0] sum);
    int hc;
    hc = hi > 511 ? 511 : hi;
    idx = 16'hFFFF;
    val = '0;
    sum = '0;
    for (int i = lo; i <= hc; i++) begin
      sum += 74'(mem[b*512+i]);
      if (idx == 16'hFFFF || mem[b*512+i] > val) begin
        val = mem[b*512+i];
        idx = 16'(i);
      end
    end
  endtask

  task automatic fill(input int nb, input int mode);
    for (int i = 0; i < nb*512; i++)
      mem[i] = mode == 0 ? 64'(i % 512) : mode == 1 ? {$urandom, $urandom} :
               mode == 2 ? 64'($urandom_range(0, 400)) : mode == 3 ? 64'd1 : 64'd0;
  endtask

  task automatic drive(input int nw, input int gmin, input int gmax, input bit scr, input int abort_at);
    for (int w = 0; w < nw; w++) begin
      repeat ($urandom_range(gmin, gmax)) begin
        valid_in = 1'b0;
        @(posedge clk); #1;
      end
      data_in = mem[w];
      valid_in = 1'b1;
      if (w == abort_at) begin
        capture_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        capture_en = 1'b1;
        valid_in = 1'b0;
        return;
      end
      if (w % 512 == 511) exp_cyc.push_back(cyc);
      @(posedge clk); #1;
      if (scr && w == 0) begin
        low_lim = 16'($urandom);
        high_lim = 16'($urandom);
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic run(input string tag, input int nb, input int nrb, input int lo, input int hi,
                     input int gmin, input int gmax, input bit scr, input int abort_at, input int npulse);
    logic [15:0] ei;
    logic [63:0] ev;
    logic [73:0] es;
    int eff;
    low_lim = 16'(lo);
    high_lim = 16'(hi);
    n_range_bins = 16'(nrb);
    eff = nrb == 0 ? 1 : nrb;
    drive(nb*512, gmin, gmax, scr, abort_at);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_count"}, q_idx.size(), npulse);
    for (int b = 0; b < npulse && b < q_idx.size() && b < exp_cyc.size(); b++) begin
      model(b, lo, hi, ei, ev, es);
      chk($sformatf("%s_idx%0d", tag, b), q_idx[b], ei);
      chk($sformatf("%s_val%0d", tag, b), q_val[b], ev);
      chk($sformatf("%s_rb%0d", tag, b), q_rb[b], b % eff);
      chk($sformatf("%s_done%0d", tag, b), q_done[b], (b % eff) == eff - 1);
      chk($sformatf("%s_lat%0d", tag, b), q_cyc[b], exp_cyc[b] + 1);
`ifdef SPEC_BAND_SUM_EN
      chk($sformatf("%s_sum%0d", tag, b), q_sum[b], es);
`else
      chk($sformatf("%s_sum%0d", tag, b), q_sum[b], 0);
`endif
    end
    chk({tag, "_err"}, err_band_o, lo > (hi > 511 ? 511 : hi));
    chk({tag, "_stray"}, stray, 0);
    q_idx.delete(); q_val.delete(); q_rb.delete(); q_done.delete(); q_sum.delete(); q_cyc.delete();
    exp_cyc.delete();
  endtask

  initial begin
    logic [15:0] ei;
    logic [63:0] ev;
    logic [73:0] es;
    int lo, hi, nrb;
    repeat (3) @(posedge clk);
    #1;
    rst_chk("reset");
    rst_n = 1'b1;
    capture_en = 1'b1;
    @(posedge clk); #1;
    fill(1, 0);
    run("ramp", 1, 1, 10, 100, 0, 0, 1, -1, 1);
    fill(1, 2); mem[20] = 64'd500; mem[40] = 64'd500;
    run("tie", 1, 1, 0, 511, 0, 0, 0, -1, 1);
    fill(1, 4);
    run("zeros", 1, 1, 5, 300, 0, 0, 0, -1, 1);
    fill(3, 2); mem[50] = 64'd5000; mem[512+60] = 64'd5000; mem[1024+70] = 64'd5000;
    run("b2b", 3, 3, 0, 511, 0, 0, 0, -1, 3);
    run("gaps", 3, 3, 0, 511, 1, 3, 0, -1, 3);
    fill(2, 1);
    run("badband", 2, 2, 300, 200, 0, 0, 0, -1, 2);
    fill(1, 0);
    run("clamp", 1, 1, 0, 1000, 0, 0, 0, -1, 1);
    fill(2, 1);
    run("abort", 2, 2, 0, 511, 0, 1, 0, 512 + 250, 1);
    model(0, 0, 511, ei, ev, es);
    chk("held_idx", peak_idx_o, ei);
    chk("held_val", peak_val_o, ev);
    chk("held_rb", rb_idx_o, 0);
    fill(2, 1);
    run("restart", 2, 2, 37, 480, 0, 0, 0, -1, 2);
    fill(1, 1);
    run("abort_last", 1, 1, 0, 511, 0, 0, 0, 511, 0);
    fill(2, 1);
    run("nrb0", 2, 0, 100, 400, 0, 0, 0, -1, 2);
    fill(1, 3);
    run("ones", 1, 1, 0, 511, 0, 0, 0, -1, 1);
    for (int k = 0; k < 3; k++) begin
      lo = $urandom_range(0, 511);
      hi = $urandom_range(0, 700);
      nrb = $urandom_range(1, 3);
      fill(nrb, 1);
      run($sformatf("rand%0d", k), nrb, nrb, lo, hi, 0, 2, 1, -1, nrb);
    end
    fill(1, 1);
    low_lim = 16'd0; high_lim = 16'd511; n_range_bins = 16'd1;
    drive(200, 0, 0, 0, -1);
    #2 rst_n = 1'b0;
    #1 rst_chk("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill(1, 0);
    run("after_reset", 1, 1, 0, 511, 0, 0, 0, -1, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
